// File: rtl/mic_req_sequencer_pkg.sv
// Shared types and default widths for the MIC requestor sequencer slice.
package mic_pkg;

  localparam int AWIDTH     = 8;
  localparam int RWIDTH     = 8;
  localparam int SEQ_CWIDTH = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_FIN
  } seq_state_t;

endpackage

// File: rtl/mic_req_sequencer_if.sv
// Command, request and status bundle between a command source and one
// MIC requestor sequencer.
interface mic_req_sequencer_if #(
  parameter int AWIDTH = 8,
  parameter int RWIDTH = 8,
  parameter int CWIDTH = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [AWIDTH-1:0] cmd_base;
  logic [CWIDTH-1:0] cmd_count;
  logic [AWIDTH-1:0] cmd_stride;
  logic              abort;
  logic              fifo_full;
  logic              req_valid;
  logic [RWIDTH-1:0] req_data;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [CWIDTH-1:0] issued;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_base, cmd_count, cmd_stride, abort, fifo_full,
    output cmd_ready, req_valid, req_data, busy, done, aborted, issued
  );

  // Command source / MIC side.
  modport master (
    output cmd_valid, cmd_base, cmd_count, cmd_stride, abort, fifo_full,
    input  cmd_ready, req_valid, req_data, busy, done, aborted, issued
  );

endinterface

// File: rtl/mic_req_sequencer_addr_gen.sv
// Address generator: current address, stride adder and remaining-request
// down-counter, driven by load/step strobes from the sequencer FSM.
module mic_addr_gen #(
  parameter int AWIDTH = 8,
  parameter int CWIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [AWIDTH-1:0] base,
  input  logic [CWIDTH-1:0] count,
  input  logic [AWIDTH-1:0] stride_in,
  output logic [AWIDTH-1:0] addr,
  output logic              last
);

  logic [AWIDTH-1:0] stride;
  logic [CWIDTH-1:0] remaining;

  // Latch the burst on load; advance address and count on each push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
      stride    <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= count;
      stride    <= stride_in;
    end else if (step) begin
      addr      <= addr + stride;
      remaining <= remaining - CWIDTH'(1);
    end
  end

  // The push in flight is the final one of the burst.
  always_comb begin
    last = (remaining == CWIDTH'(1));
  end

endmodule

// File: rtl/mic_req_sequencer.sv
// Turns a burst command (base, count, stride) into single-word MIC read
// requests, honouring per-port fifo_full backpressure and abort.
module mic_req_sequencer #(
  parameter int AWIDTH = mic_pkg::AWIDTH,
  parameter int RWIDTH = mic_pkg::RWIDTH,
  parameter int CWIDTH = mic_pkg::SEQ_CWIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  mic_req_sequencer_if.slave   bus
);

  import mic_pkg::*;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              accept;
  logic              push;
  logic              last;
  logic [AWIDTH-1:0] addr;
  logic [CWIDTH-1:0] issued_q;
  logic              aborted_q;

  assign accept = bus.cmd_valid & bus.cmd_ready;

  mic_addr_gen #(
    .AWIDTH (AWIDTH),
    .CWIDTH (CWIDTH)
  ) u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .step      (push),
    .base      (bus.cmd_base),
    .count     (bus.cmd_count),
    .stride_in (bus.cmd_stride),
    .addr      (addr),
    .last      (last)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SEQ_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort only matters while issuing.
  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_IDLE: begin
        if (accept) state_nxt = (bus.cmd_count != '0) ? SEQ_ISSUE : SEQ_FIN;
      end
      SEQ_ISSUE: begin
        if (bus.abort)       state_nxt = SEQ_FIN;
        else if (push && last) state_nxt = SEQ_FIN;
      end
      SEQ_FIN:  state_nxt = SEQ_IDLE;
      default:  state_nxt = SEQ_IDLE;
    endcase
  end

  // State-decoded outputs; the push is combinational so the MIC samples it
  // on the same edge that advances the address.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    push          = 1'b0;
    case (state)
      SEQ_IDLE:  bus.cmd_ready = ~reset;
      SEQ_ISSUE: begin
        bus.busy = 1'b1;
        push     = ~bus.fifo_full & ~bus.abort;
      end
      SEQ_FIN:   bus.done = 1'b1;
      default:   ;
    endcase
  end

  // Issued-count and abort-status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_q  <= '0;
      aborted_q <= 1'b0;
    end else if (accept) begin
      issued_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (push) issued_q <= issued_q + CWIDTH'(1);
      if (state == SEQ_ISSUE && bus.abort) aborted_q <= 1'b1;
    end
  end

  assign bus.req_valid = push;
  assign bus.req_data  = RWIDTH'(addr);
  assign bus.issued    = issued_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_mic_req_sequencer.sv
// Directed bench for mic_req_sequencer: cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_mic_req_sequencer;

  localparam int AW = 8;
  localparam int RW = 8;
  localparam int CW = 8;

  logic clock;
  logic reset;

  mic_req_sequencer_if #(.AWIDTH(AW), .RWIDTH(RW), .CWIDTH(CW)) bus ();

  mic_req_sequencer #(.AWIDTH(AW), .RWIDTH(RW), .CWIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          cv;
    logic [AW-1:0] base;
    logic [CW-1:0] count;
    logic [AW-1:0] stride;
    logic          ab;
    logic          ff;
    logic          rv;
    logic [RW-1:0] data;
    logic          busy;
    logic          done;
    logic          abd;
    logic          cr;
    logic [CW-1:0] iss;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic cv, input int base, input int count, input int stride,
                      input logic ab, input logic ff, input logic rv, input int data,
                      input logic busy, input logic done, input logic abd, input logic cr,
                      input int iss);
    vec_t v;
    v.cv = cv; v.base = AW'(base); v.count = CW'(count); v.stride = AW'(stride);
    v.ab = ab; v.ff = ff; v.rv = rv; v.data = RW'(data);
    v.busy = busy; v.done = done; v.abd = abd; v.cr = cr; v.iss = CW'(iss);
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_count = '0;
    bus.cmd_stride = '0; bus.abort = 1'b0; bus.fifo_full = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    #2;
    check("rst_req_valid", bus.req_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);

    //   cv base cnt str ab ff | rv data busy done abd cr iss
    // Basic burst
    addv(1, 'h10, 4, 1, 0, 0,   0, 0,    0, 0, 0, 1, 0);
    addv(0, 0,    0, 0, 0, 0,   1, 'h10, 1, 0, 0, 0, 0);
    addv(0, 0,    0, 0, 0, 0,   1, 'h11, 1, 0, 0, 0, 1);
    addv(0, 0,    0, 0, 0, 0,   1, 'h12, 1, 0, 0, 0, 2);
    addv(0, 0,    0, 0, 0, 0,   1, 'h13, 1, 0, 0, 0, 3);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 1, 0, 0, 4);
    // Backpressure on 2nd and 3rd ISSUE cycles
    addv(1, 'h20, 4, 2, 0, 0,   0, 0,    0, 0, 0, 1, 4);
    addv(0, 0,    0, 0, 0, 0,   1, 'h20, 1, 0, 0, 0, 0);
    addv(0, 0,    0, 0, 0, 1,   0, 0,    1, 0, 0, 0, 1);
    addv(0, 0,    0, 0, 0, 1,   0, 0,    1, 0, 0, 0, 1);
    addv(0, 0,    0, 0, 0, 0,   1, 'h22, 1, 0, 0, 0, 1);
    addv(0, 0,    0, 0, 0, 0,   1, 'h24, 1, 0, 0, 0, 2);
    addv(0, 0,    0, 0, 0, 0,   1, 'h26, 1, 0, 0, 0, 3);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 1, 0, 0, 4);
    // Address wrap; abort during FIN is ignored
    addv(1, 'hFE, 3, 1, 0, 0,   0, 0,    0, 0, 0, 1, 4);
    addv(0, 0,    0, 0, 0, 0,   1, 'hFE, 1, 0, 0, 0, 0);
    addv(0, 0,    0, 0, 0, 0,   1, 'hFF, 1, 0, 0, 0, 1);
    addv(0, 0,    0, 0, 0, 0,   1, 'h00, 1, 0, 0, 0, 2);
    addv(0, 0,    0, 0, 1, 0,   0, 0,    0, 1, 0, 0, 3);
    // Zero-count command
    addv(1, 'h33, 0, 1, 0, 0,   0, 0,    0, 0, 0, 1, 3);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 1, 0, 0, 0);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 0, 0, 1, 0);
    // Abort on the 3rd request, together with fifo_full
    addv(1, 'h40, 8, 4, 0, 0,   0, 0,    0, 0, 0, 1, 0);
    addv(0, 0,    0, 0, 0, 0,   1, 'h40, 1, 0, 0, 0, 0);
    addv(0, 0,    0, 0, 0, 0,   1, 'h44, 1, 0, 0, 0, 1);
    addv(0, 0,    0, 0, 1, 1,   0, 0,    1, 0, 0, 0, 2);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 1, 1, 0, 2);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 0, 1, 1, 2);
    // New command accepted (abort in IDLE ignored), aborted clears
    addv(1, 'h50, 1, 1, 1, 0,   0, 0,    0, 0, 1, 1, 2);
    addv(0, 0,    0, 0, 0, 0,   1, 'h50, 1, 0, 0, 0, 0);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 1, 0, 0, 1);
    // Back-to-back: cmd_valid held, inputs change mid-burst
    addv(1, 'h60, 2, 1, 0, 0,   0, 0,    0, 0, 0, 1, 1);
    addv(1, 'h70, 1, 3, 0, 0,   1, 'h60, 1, 0, 0, 0, 0);
    addv(1, 'h70, 1, 3, 0, 0,   1, 'h61, 1, 0, 0, 0, 1);
    addv(1, 'h70, 1, 3, 0, 0,   0, 0,    0, 1, 0, 0, 2);
    addv(1, 'h70, 1, 3, 0, 0,   0, 0,    0, 0, 0, 1, 2);
    addv(0, 0,    0, 0, 0, 0,   1, 'h70, 1, 0, 0, 0, 0);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 1, 0, 0, 1);
    addv(0, 0,    0, 0, 0, 0,   0, 0,    0, 0, 0, 1, 1);

    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Table: inputs applied just after a rising edge, outputs checked at the falling edge.
    for (int i = 0; i < vecs.size(); i++) begin
      bus.cmd_valid  = vecs[i].cv;
      bus.cmd_base   = vecs[i].base;
      bus.cmd_count  = vecs[i].count;
      bus.cmd_stride = vecs[i].stride;
      bus.abort      = vecs[i].ab;
      bus.fifo_full  = vecs[i].ff;
      @(negedge clock);
      check($sformatf("v%0d_req_valid", i), bus.req_valid, vecs[i].rv);
      if (vecs[i].rv) check($sformatf("v%0d_req_data", i), bus.req_data, vecs[i].data);
      check($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
      check($sformatf("v%0d_done", i), bus.done, vecs[i].done);
      check($sformatf("v%0d_aborted", i), bus.aborted, vecs[i].abd);
      check($sformatf("v%0d_cmd_ready", i), bus.cmd_ready, vecs[i].cr);
      check($sformatf("v%0d_issued", i), bus.issued, vecs[i].iss);
      @(posedge clock); #1;
    end

    // Reset mid-burst: base 0x80, count 5, asserted after two pushes.
    drive_idle();
    bus.cmd_valid = 1'b1; bus.cmd_base = 8'h80; bus.cmd_count = 8'd5; bus.cmd_stride = 8'd1;
    @(posedge clock); #1;
    drive_idle();
    @(negedge clock);
    check("mr_push0", bus.req_data, 'h80);
    @(posedge clock); #1;
    @(negedge clock);
    check("mr_push1", bus.req_data, 'h81);
    @(posedge clock); #1;
    check("mr_pre_valid", bus.req_valid, 1);
    reset = 1'b1;
    #1;
    check("mr_valid_drop", bus.req_valid, 0);
    check("mr_busy_drop", bus.busy, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mr_busy", bus.busy, 0);
    check("mr_cmd_ready", bus.cmd_ready, 1);
    check("mr_issued", bus.issued, 0);
    check("mr_aborted", bus.aborted, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mr_no_done%0d", k), bus.done, 0);
      check($sformatf("mr_no_req%0d", k), bus.req_valid, 0);
      @(negedge clock);
    end

    // Sequencer is usable again after reset.
    @(posedge clock); #1;
    bus.cmd_valid = 1'b1; bus.cmd_base = 8'hA0; bus.cmd_count = 8'd1; bus.cmd_stride = 8'd5;
    @(posedge clock); #1;
    drive_idle();
    @(negedge clock);
    check("post_req_valid", bus.req_valid, 1);
    check("post_req_data", bus.req_data, 'hA0);
    @(negedge clock);
    check("post_done", bus.done, 1);
    check("post_issued", bus.issued, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
